uart_tx_fifo_ctrl: RTL and testbench



---
 rtl/uart_tx_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// rtl/uart_tx_fifo_ctrl.sv - UART transmit FIFO and one-byte-at-a-time launch controller (UART_TX_FIFO_OVF_EN adds sticky overflow flag)
module uart_tx_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_din,
    input  logic              tx_done_tick,
    output logic              busy,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              pop, push;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign busy  = (state != IDLE) || !empty;
    // A full FIFO still accepts a write on the edge that pops a byte out.
    assign push  = wr && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!empty) state_next = WAIT_DONE;
            WAIT_DONE: if (tx_done_tick) state_next = GAP;
            GAP:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        pop = (state == IDLE) && !empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            tx_start <= pop;
            if (pop) tx_din <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= w_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic drop;
    assign drop = wr && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb/tb_uart_tx_fifo_ctrl.sv - randomized self-checking bench for uart_tx_fifo_ctrl against a queue-based model
module tb_uart_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] w_data = '0;
    logic       full, empty, tx_start, busy, ovf;
    logic [4:0] count;
    logic [7:0] tx_din;
    logic       tx_done_tick = 1'b0;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data),
        .full(full), .empty(empty), .count(count),
        .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
        .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Model: byte queue plus the edge index from which the launcher may fire again.
    logic [7:0] q[$];
    int         edge_no;
    int         ready_at;
    bit         waiting;
    bit         exp_start;
    logic [7:0] exp_din;
    bit         exp_ovf;

    // Transmitter stand-in: answers each launch with tx_done_tick after tx_delay cycles.
    int tx_cnt;
    int tx_delay;
    bit hold_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        edge_no   = 0;
        ready_at  = 0;
        waiting   = 0;
        exp_start = 0;
        exp_din   = '0;
        exp_ovf   = 0;
        tx_cnt    = 0;
    endtask

    task automatic model_edge();
        int n;
        bit launch;
        n = q.size();
        launch = !waiting && (edge_no >= ready_at) && (n > 0);
        exp_start = launch;
        if (launch) exp_din = q.pop_front();
        if (wr && (n < 16 || launch)) q.push_back(w_data);
`ifdef UART_TX_FIFO_OVF_EN
        if (wr && n == 16 && !launch) exp_ovf = 1;
        else if (ovf_clr)             exp_ovf = 0;
`endif
        if (waiting && tx_done_tick) begin
            waiting  = 0;
            ready_at = edge_no + 2;
        end
        if (launch) waiting = 1;
        edge_no++;
    endtask

    task automatic check_all();
        bit exp_busy;
        exp_busy = waiting || (edge_no < ready_at) || (q.size() > 0);
        check("tx_start", 32'(tx_start), 32'(exp_start));
        check("tx_din",   32'(tx_din),   32'(exp_din));
        check("count",    32'(count),    32'(q.size()));
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("full",     32'(full),     32'(q.size() == 16));
        check("busy",     32'(busy),     32'(exp_busy));
        check("ovf",      32'(ovf),      32'(exp_ovf));
    endtask

    // Called at a negedge: drive inputs, advance model, clock, then compare.
    task automatic cycle(input bit w, input logic [7:0] d, input bit clr);
        wr      = w;
        w_data  = d;
        ovf_clr = clr;
        tx_done_tick = !hold_done && (tx_cnt == 1);
        if (!hold_done && tx_cnt > 0) tx_cnt--;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
        if (exp_start) tx_cnt = tx_delay;
    endtask

    initial begin
        logic [7:0] seq;
        hold_done = 0;
        tx_delay  = 5;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all();

        // Single byte
        cycle(1, 8'hA5, 0);
        repeat (15) cycle(0, 8'h00, 0);

        // Burst ordering with a slow transmitter
        tx_delay = 20;
        for (int i = 1; i <= 5; i++) cycle(1, 8'(i), 0);
        repeat (120) cycle(0, 8'h00, 0);

        // Fill past capacity with the transmitter stalled
        hold_done = 1;
        for (int i = 0; i < 18; i++) cycle(1, 8'(8'h10 + i), 0);
        check("full_after_fill", 32'(count), 32'd16);
        cycle(0, 8'h00, 1);

        // Keep writing while full as the launcher drains
        hold_done = 0;
        tx_delay  = 3;
        seq = 8'h77;
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 16) begin
                cycle(1, seq, 0);
                seq++;
            end else begin
                cycle(0, 8'h00, 0);
            end
        end
        repeat (150) cycle(0, 8'h00, 0);

        // Randomized mixed bursts across pointer wrap
        for (int blk = 0; blk < 60; blk++) begin
            int wprob;
            wprob    = $urandom_range(0, 100);
            tx_delay = $urandom_range(1, 8);
            for (int i = 0; i < 25; i++)
                cycle(($urandom_range(0, 99) < wprob), 8'($urandom), ($urandom_range(0, 15) == 0));
        end
        repeat (200) cycle(0, 8'h00, 0);

        // Reset while a byte is in flight with three more queued
        tx_delay = 20;
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'hC0 + i), 0);
        check("pre_reset_count", 32'(count), 32'd3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) cycle(0, 8'h00, 0);
        cycle(1, 8'h3C, 0);
        cycle(0, 8'h00, 0);
        check("post_reset_launch", 32'(tx_din), 32'h3C);
        repeat (30) cycle(0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
